// File: rtl/line_credit_feeder.sv
// line_credit_feeder: buffers DMA pixels in a small FIFO and forwards them line by line against
// downstream line-buffer credits. Defining FEEDER_STATS_EN adds the out_stall_cycles counter.
`timescale 1ns/1ps
module line_credit_feeder #(
  parameter int LINE_WIDTH  = 512,
  parameter int NUM_CREDITS = 4,
  parameter int FRAME_LINES = 512,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_start,
  input  logic [7:0]  in_s_data,
  input  logic        in_s_valid,
  output logic        out_s_ready,
  output logic [7:0]  out_pixel_data,
  output logic        out_pixel_data_valid,
  input  logic        in_intr,
  output logic        out_frame_done,
`ifdef FEEDER_STATS_EN
  output logic [31:0] out_stall_cycles,
`endif
  output logic        out_credit_err
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH + 1);
  localparam int CW   = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int LW   = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int CRW  = $clog2(NUM_CREDITS + 1);

  localparam logic [CW-1:0]   COL_LAST    = CW'(LINE_WIDTH - 1);
  localparam logic [LW-1:0]   LINE_LAST   = LW'(FRAME_LINES - 1);
  localparam logic [CRW-1:0]  CREDITS_MAX = CRW'(NUM_CREDITS);
  localparam logic [CNTW-1:0] FIFO_FULL   = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_SEND        = 2'd1,
    S_WAIT_CREDIT = 2'd2,
    S_DONE        = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CW-1:0]   col_q, col_d;
  logic [LW-1:0]   line_q, line_d;
  logic [CRW-1:0]  credits_q, credits_d;
  logic            err_q, err_d;
  logic [7:0]      pix_q, pix_d;
  logic            pix_valid_q, pix_valid_d;
  logic            frame_done_q, frame_done_d;

  logic fifo_empty_s;
  logic push_s;
  logic send_s;
  logic col_zero_s;
  logic col_last_s;
  logic line_last_s;
  logic take_credit_s;

  assign fifo_empty_s  = (count_q == '0);
  assign out_s_ready   = (count_q != FIFO_FULL);
  assign push_s        = in_s_valid & out_s_ready;
  assign col_zero_s    = (col_q == '0);
  assign col_last_s    = (col_q == COL_LAST);
  assign line_last_s   = (line_q == LINE_LAST);
  // a line may only start when a credit is available; the rest of the line is already paid for
  assign send_s        = (state_q == S_SEND) && !fifo_empty_s && (!col_zero_s || (credits_q != '0));
  assign take_credit_s = send_s & col_zero_s;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = in_s_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (send_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, send_s})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (take_credit_s && !in_intr) begin
      credits_d = credits_q - CRW'(1);
    end else if (!take_credit_s && in_intr) begin
      if (credits_q == CREDITS_MAX) begin
        err_d = 1'b1;
      end else begin
        credits_d = credits_q + CRW'(1);
      end
    end else begin
      credits_d = credits_q;
    end
  end

  always_comb begin
    col_d  = col_q;
    line_d = line_q;
    if (send_s) begin
      col_d = col_last_s ? '0 : col_q + CW'(1);
      if (col_last_s) begin
        line_d = line_last_s ? '0 : line_q + LW'(1);
      end else begin
        line_d = line_q;
      end
    end else begin
      col_d = col_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    pix_d        = send_s ? mem_q[rd_ptr_q] : pix_q;
    pix_valid_d  = send_s;
    frame_done_d = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (in_start) state_d = S_SEND;
        else          state_d = S_IDLE;
      end
      S_SEND: begin
        // a same-cycle in_intr keeps the line start alive
        if (send_s && col_last_s && line_last_s)                   state_d = S_DONE;
        else if (col_zero_s && (credits_q == '0) && !in_intr)      state_d = S_WAIT_CREDIT;
        else                                                       state_d = S_SEND;
      end
      S_WAIT_CREDIT: begin
        if ((credits_q != '0) || in_intr) state_d = S_SEND;
        else                              state_d = S_WAIT_CREDIT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      col_q        <= '0;
      line_q       <= '0;
      credits_q    <= CREDITS_MAX;
      err_q        <= 1'b0;
      pix_q        <= 8'd0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      col_q        <= col_d;
      line_q       <= line_d;
      credits_q    <= credits_d;
      err_q        <= err_d;
      pix_q        <= pix_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_pixel_data       = pix_q;
  assign out_pixel_data_valid = pix_valid_q;
  assign out_frame_done       = frame_done_q;
  assign out_credit_err       = err_q;

`ifdef FEEDER_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == S_WAIT_CREDIT) && !fifo_empty_s && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) stall_q <= 32'd0;
    else        stall_q <= stall_d;
  end

  assign out_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_line_credit_feeder.sv
// Self-checking bench for line_credit_feeder: scoreboarded pixel stream on a full-size instance
// plus a table of short frames on a LINE_WIDTH=8, FRAME_LINES=2 instance.
`timescale 1ns/1ps
module tb_line_credit_feeder;

  logic        in_clk;
  logic        in_rst;
  logic        in_start;
  logic [7:0]  in_s_data;
  logic        in_s_valid;
  logic        out_s_ready;
  logic [7:0]  out_pixel_data;
  logic        out_pixel_data_valid;
  logic        in_intr;
  logic        out_frame_done;
  logic        out_credit_err;
  logic [31:0] stall_cycles;

  logic        s_start, s_valid, s_ready, s_pix_valid, s_intr, s_done, s_err;
  logic [7:0]  s_data, s_pix;
  logic [31:0] s_stall;

  int checks;
  int fails;
  int vcnt;
  int fed;
  int feed_target;
  logic [7:0] exp_q[$];
  logic [7:0] s_q[$];

  line_credit_feeder dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_start(in_start),
    .in_s_data(in_s_data), .in_s_valid(in_s_valid), .out_s_ready(out_s_ready),
    .out_pixel_data(out_pixel_data), .out_pixel_data_valid(out_pixel_data_valid),
    .in_intr(in_intr), .out_frame_done(out_frame_done),
`ifdef FEEDER_STATS_EN
    .out_stall_cycles(stall_cycles),
`endif
    .out_credit_err(out_credit_err)
  );

  line_credit_feeder #(.LINE_WIDTH(8), .FRAME_LINES(2)) dut_small (
    .in_clk(in_clk), .in_rst(in_rst), .in_start(s_start),
    .in_s_data(s_data), .in_s_valid(s_valid), .out_s_ready(s_ready),
    .out_pixel_data(s_pix), .out_pixel_data_valid(s_pix_valid),
    .in_intr(s_intr), .out_frame_done(s_done),
`ifdef FEEDER_STATS_EN
    .out_stall_cycles(s_stall),
`endif
    .out_credit_err(s_err)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) & 255);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives the DMA side of the big instance and scores its output stream every falling edge.
  task automatic pump();
    logic [7:0] e;
    forever begin
      @(negedge in_clk);
      if (in_rst) begin
        exp_q.delete();
        in_s_valid = 1'b0;
      end else begin
        if (out_pixel_data_valid) begin
          vcnt++;
          if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL pixel_unexpected: got %0d, expected no pixel", out_pixel_data);
          end else begin
            e = exp_q.pop_front();
            check("pixel_data", int'(out_pixel_data), int'(e));
          end
        end
        if (fed < feed_target) begin
          in_s_data  = pat(fed);
          in_s_valid = 1'b1;
          if (out_s_ready) begin
            exp_q.push_back(pat(fed));
            fed++;
          end
        end else begin
          in_s_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_vcnt(input string name, input int target, input int budget);
    int n = 0;
    while (vcnt < target && n < budget) begin
      @(negedge in_clk);
      #1;
      n++;
    end
    check(name, int'(vcnt >= target), 1);
  endtask

  task automatic pulse_start();
    @(negedge in_clk);
    in_start = 1'b1;
    @(negedge in_clk);
    in_start = 1'b0;
  endtask

  task automatic pulse_intr(input int n);
    @(negedge in_clk);
    in_intr = 1'b1;
    repeat (n) @(negedge in_clk);
    in_intr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge in_clk);
    #2;
    in_rst = 1'b1;
    feed_target = fed;
    #1;
    check("rst_valid_now", int'(out_pixel_data_valid), 0);
    check("rst_ready_now", int'(out_s_ready), 1);
    repeat (2) @(negedge in_clk);
    #2;
    in_rst = 1'b0;
  endtask

  typedef struct {
    int n_pix;
    bit use_intr;
    int exp_valid;
    int exp_done;
  } frame_vec_t;

  task automatic run_small_frame(input int idx, input frame_vec_t v);
    int scnt = 0, dcnt = 0, cyc = 0, last_cyc = -1, done_cyc = -1;
    logic [7:0] e;
    for (int i = 0; i < v.n_pix; i++) begin
      @(negedge in_clk);
      s_data  = pat(1000 + idx * 64 + i);
      s_valid = 1'b1;
      if (s_ready) s_q.push_back(s_data);
    end
    @(negedge in_clk);
    s_valid = 1'b0;
    s_start = 1'b1;
    @(negedge in_clk);
    s_start = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge in_clk);
      cyc++;
      s_intr = 1'b0;
      if (s_pix_valid) begin
        scnt++;
        if (s_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL small_unexpected: got %0d, expected no pixel", s_pix);
        end else begin
          e = s_q.pop_front();
          check("small_data", int'(s_pix), int'(e));
        end
        if (scnt == v.n_pix) last_cyc = cyc;
        if (v.use_intr && (scnt % 8 == 0)) s_intr = 1'b1;
      end
      if (s_done) begin
        dcnt++;
        done_cyc = cyc;
      end
    end
    s_intr = 1'b0;
    check($sformatf("small_valid_%0d", idx), scnt, v.exp_valid);
    check($sformatf("small_done_%0d", idx), dcnt, v.exp_done);
    check($sformatf("small_left_%0d", idx), s_q.size(), v.n_pix - v.exp_valid);
    if (v.exp_done != 0) check($sformatf("small_done_lag_%0d", idx), done_cyc - last_cyc, 1);
  endtask

  initial begin
    frame_vec_t vecs [5];
    int v0, f0, run, n;
    int s1, s2;
    vecs[0] = '{n_pix: 16, use_intr: 1'b1, exp_valid: 16, exp_done: 1};
    vecs[1] = '{n_pix: 16, use_intr: 1'b1, exp_valid: 16, exp_done: 1};
    vecs[2] = '{n_pix: 16, use_intr: 1'b0, exp_valid: 16, exp_done: 1};
    vecs[3] = '{n_pix: 16, use_intr: 1'b0, exp_valid: 16, exp_done: 1};
    vecs[4] = '{n_pix: 16, use_intr: 1'b0, exp_valid: 0,  exp_done: 0};

    checks = 0; fails = 0; vcnt = 0; fed = 0; feed_target = 0;
    in_rst = 1'b1; in_start = 1'b0; in_intr = 1'b0; in_s_valid = 1'b0; in_s_data = 8'd0;
    s_start = 1'b0; s_valid = 1'b0; s_data = 8'd0; s_intr = 1'b0;
    fork
      pump();
    join_none

    repeat (3) @(negedge in_clk);
    check("reset_data", int'(out_pixel_data), 0);
    check("reset_valid", int'(out_pixel_data_valid), 0);
    check("reset_done", int'(out_frame_done), 0);
    check("reset_err", int'(out_credit_err), 0);
    check("reset_ready", int'(out_s_ready), 1);
    #2;
    in_rst = 1'b0;

    // reset in the middle of the first line
    pulse_start();
    feed_target = fed + 1000;
    wait_vcnt("midline_reach", 100, 500);
    do_reset();

    // four credits carry exactly four lines, then the FIFO fills behind the stall
    pulse_start();
    v0 = vcnt; f0 = fed;
    feed_target = fed + 5 * 512;
    wait_vcnt("four_lines_reach", v0 + 2048, 6000);
    repeat (200) @(negedge in_clk);
    #1;
    check("four_lines_count", vcnt - v0, 2048);
    check("stall_ready", int'(out_s_ready), 0);
    check("stall_queued", exp_q.size(), 16);
    check("stall_accepted", fed - f0, 2064);
`ifdef FEEDER_STATS_EN
    s1 = int'(stall_cycles);
    repeat (10) @(negedge in_clk);
    s2 = int'(stall_cycles);
    check("stall_cnt_inc", s2 - s1, 10);
`endif

    // one returned credit releases exactly one line
    v0 = vcnt;
    feed_target = fed + 600;
    pulse_intr(1);
`ifdef FEEDER_STATS_EN
    @(negedge in_clk);
    s1 = int'(stall_cycles);
    repeat (100) @(negedge in_clk);
    s2 = int'(stall_cycles);
    check("stall_cnt_hold", s2 - s1, 0);
`endif
    wait_vcnt("one_line_reach", v0 + 512, 2000);
    repeat (200) @(negedge in_clk);
    #1;
    check("one_line_count", vcnt - v0, 512);
    check("one_line_ready", int'(out_s_ready), 0);

    // intr coincides with the col-0 send: two back-to-back lines without a gap
    v0 = vcnt;
    feed_target = fed + 1100;
    pulse_intr(2);
    run = 0; n = 0;
    while (!out_pixel_data_valid && n < 50) begin
      @(negedge in_clk);
      n++;
    end
    while (out_pixel_data_valid && run < 3000) begin
      run++;
      @(negedge in_clk);
    end
    check("same_cycle_run", run, 1024);
    repeat (200) @(negedge in_clk);
    #1;
    check("same_cycle_count", vcnt - v0, 1024);
    check("same_cycle_ready", int'(out_s_ready), 0);

    // surplus credit return on a fresh reset
    do_reset();
    @(negedge in_clk);
    check("err_clear", int'(out_credit_err), 0);
    pulse_intr(1);
    check("err_set", int'(out_credit_err), 1);
    repeat (1000) @(negedge in_clk);
    check("err_sticky", int'(out_credit_err), 1);
    pulse_start();
    v0 = vcnt;
    feed_target = fed + 2200;
    wait_vcnt("sat_reach", v0 + 2048, 6000);
    repeat (300) @(negedge in_clk);
    #1;
    check("sat_count", vcnt - v0, 2048);

    // short frames on the small instance
    for (int i = 0; i < 5; i++) run_small_frame(i, vecs[i]);
    check("small_err", int'(s_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
